// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the boot-time system ID checker.
// SYSID_CHECKER_TS_CHECK_EN adds the timestamp read state.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
`ifdef SYSID_CHECKER_TS_CHECK_EN
    RD_TS = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_checker_timeout.sv
// Saturating stall counter shared by both read states; clear reloads zero.
module sysid_checker_timeout
  import sysid_checker_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = tmo_cnt_w(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT_C);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID/timestamp after reset and flags mismatch.
// Define SYSID_CHECKER_TS_CHECK_EN to also read and check the timestamp register.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd11,
  parameter logic [31:0] EXPECTED_TS    = 32'd1447592398,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state, state_nxt;
  logic   rd_nxt, addr_nxt, in_read, tmo_expired, tmo_clear, tmo_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    addr_nxt  = ADDR_ID;
    in_read   = (state == RD_ID);
    case (state)
      IDLE:  state_nxt = RD_ID;
`ifdef SYSID_CHECKER_TS_CHECK_EN
      RD_ID: begin
        if (!avm_waitrequest)  state_nxt = RD_TS;
        else if (tmo_expired)  state_nxt = DONE;
      end
      RD_TS: if (!avm_waitrequest || tmo_expired) state_nxt = DONE;
`else
      RD_ID: if (!avm_waitrequest || tmo_expired) state_nxt = DONE;
`endif
      DONE:  if (start) state_nxt = RD_ID;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == RD_ID) rd_nxt = 1'b1;
`ifdef SYSID_CHECKER_TS_CHECK_EN
    if (state == RD_TS) in_read = 1'b1;
    if (state_nxt == RD_TS) begin
      rd_nxt   = 1'b1;
      addr_nxt = ADDR_TS;
    end
`endif
  end

  // Any state change restarts the stall count, so each read gets a fresh budget.
  assign tmo_clear = (state_nxt != state);
  assign tmo_en    = in_read && avm_waitrequest;

  sysid_checker_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmo_clear),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
    end else begin
      avm_read    <= rd_nxt;
      avm_address <= addr_nxt;
      busy        <= rd_nxt;
      done        <= (state_nxt == DONE);
      if ((state == DONE) && start) begin
        id_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if ((state == RD_ID) && !avm_waitrequest) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (in_read && avm_waitrequest && tmo_expired) timeout <= 1'b1;
    end
  end

`ifdef SYSID_CHECKER_TS_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_ok    <= 1'b0;
      ts_value <= '0;
    end else begin
      if ((state == DONE) && start) ts_ok <= 1'b0;
      if ((state == RD_TS) && !avm_waitrequest) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
    end
  end
`else
  // Without a timestamp read the timestamp is treated as matching once done.
  assign ts_ok    = done;
  assign ts_value = '0;
`endif

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a scripted wait-state slave and a timeline model.
module tb_sysid_checker;
  import sysid_checker_pkg::*;

  localparam int          TMO    = 4;
  localparam logic [31:0] EXP_ID = 32'd11;
  localparam logic [31:0] EXP_TS = 32'd1447592398;
`ifdef SYSID_CHECKER_TS_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int ZW_DONE  = TS_EN ? 2 : 1;
  localparam int ST3_DONE = TS_EN ? 8 : 4;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] avm_readdata = '0, id_value, ts_value;
  logic        avm_waitrequest = 1'b0;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at edge %0d",
               name, act, act, exp, exp, edge_n);
    end
  endtask

  // Slave script: wait cycles and data per register.
  int          s_wid = 0, s_wts = 0;
  logic [31:0] s_id = EXP_ID, s_ts = EXP_TS;

  // Parameters of the check run the model is predicting.
  bit          in_reset = 1'b1;
  int          e0 = 0, r_wid = 0, r_wts = 0;
  logic [31:0] r_id = '0, r_ts = '0, p_id = '0, p_ts = '0;

  typedef struct packed {
    logic rd, addr, busy, done, id_ok, ts_ok, to;
    logic [31:0] idv, tsv;
  } exp_t;

  // Edges spent in one read: the accepting edge, or the edge that times out.
  function automatic int seg(input int w);
    return (w <= TMO) ? w + 1 : TMO + 1;
  endfunction

  function automatic int done_k();
    if (TS_EN && (r_wid <= TMO)) return seg(r_wid) + seg(r_wts);
    return seg(r_wid);
  endfunction

  // Expected outputs after edge e0+k of the current run.
  function automatic exp_t model(input int k);
    exp_t e;
    bit   id_to, ts_to;
    e = '0;
    if (in_reset) return e;
    id_to = (r_wid > TMO);
    ts_to = TS_EN && !id_to && (r_wts > TMO);
    e.idv = p_id;
    e.tsv = TS_EN ? p_ts : 32'd0;
    if (k < seg(r_wid)) begin
      e.rd = 1'b1; e.busy = 1'b1;
    end else if (k < done_k()) begin
      e.rd = 1'b1; e.busy = 1'b1; e.addr = 1'b1;
      e.id_ok = (r_id == EXP_ID); e.idv = r_id;
    end else begin
      e.done = 1'b1;
      e.to   = id_to || ts_to;
      if (!id_to) begin
        e.id_ok = (r_id == EXP_ID); e.idv = r_id;
      end
      if (!TS_EN) e.ts_ok = 1'b1;
      else if (!id_to && !ts_to) begin
        e.ts_ok = (r_ts == EXP_TS); e.tsv = r_ts;
      end
    end
    return e;
  endfunction

  task automatic begin_run();
    exp_t f;
    if (!in_reset) begin
      f = model(1 << 20);
      p_id = f.idv; p_ts = f.tsv;
    end
    in_reset = 1'b0;
    e0 = edge_n;
    r_wid = s_wid; r_wts = s_wts; r_id = s_id; r_ts = s_ts;
  endtask

  // Slave: stalls the first N cycles of each new read, then returns data.
  initial begin
    int   s_cnt;
    logic prev_rd, prev_addr;
    s_cnt = 0; prev_rd = 1'b0; prev_addr = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (avm_read) begin
        if (!prev_rd || (avm_address != prev_addr)) s_cnt = 0;
        avm_waitrequest = (s_cnt < (avm_address ? s_wts : s_wid));
        avm_readdata    = avm_address ? s_ts : s_id;
        s_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hDEAD_BEEF;
      end
      prev_rd = avm_read; prev_addr = avm_address;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      e = model(edge_n - e0);
      chk("avm_read",    avm_read,    e.rd);
      chk("avm_address", avm_address, e.addr);
      chk("busy",        busy,        e.busy);
      chk("done",        done,        e.done);
      chk("id_ok",       id_ok,       e.id_ok);
      chk("ts_ok",       ts_ok,       e.ts_ok);
      chk("timeout",     timeout,     e.to);
      chk("id_value",    id_value,    e.idv);
      chk("ts_value",    ts_value,    e.tsv);
    end
  end

  task automatic at_k(input int k);
    while (edge_n < e0 + k) begin @(posedge clock); #1; end
    #2;
  endtask

  task automatic start_run();
    @(posedge clock); #2; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    begin_run();
  endtask

  task automatic release_reset();
    @(posedge clock); #2; reset = 1'b0;
    @(posedge clock); #1;
    begin_run();
  endtask

  // Pulse start so that it is sampled at edge e0+k.
  task automatic pulse_at(input int k);
    while (edge_n < e0 + k - 1) begin @(posedge clock); #1; end
    #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #3;
    chk("lit_reset_read", avm_read, 1'b0);
    chk("lit_reset_idv",  id_value, 32'd0);

    // Zero-wait, correct slave.
    release_reset();
    at_k(ZW_DONE - 1);
    chk("lit_zw_done_early", done, 1'b0);
    at_k(ZW_DONE);
    chk("lit_zw_done",  done,    1'b1);
    chk("lit_zw_id_ok", id_ok,   1'b1);
    chk("lit_zw_ts_ok", ts_ok,   1'b1);
    chk("lit_zw_to",    timeout, 1'b0);
    chk("lit_zw_idv",   id_value, 32'd11);
    at_k(ZW_DONE + 2);

    // Wrong ID.
    s_id = 32'd12;
    start_run();
    at_k(ZW_DONE);
    chk("lit_bad_id_ok", id_ok,    1'b0);
    chk("lit_bad_idv",   id_value, 32'd12);
    chk("lit_bad_ts_ok", ts_ok,    1'b1);
    at_k(ZW_DONE + 2);

    // Three wait cycles on each read.
    s_id = EXP_ID; s_wid = 3; s_wts = 3;
    start_run();
    at_k(ST3_DONE - 1);
    chk("lit_st3_done_early", done, 1'b0);
    at_k(ST3_DONE);
    chk("lit_st3_done", done,  1'b1);
    chk("lit_st3_id_ok", id_ok, 1'b1);
    at_k(ST3_DONE + 2);

    // Stuck waitrequest on the ID read.
    s_wid = 1000; s_wts = 0;
    start_run();
    at_k(4);
    chk("lit_to_early", timeout, 1'b0);
    at_k(5);
    chk("lit_to",      timeout,  1'b1);
    chk("lit_to_read", avm_read, 1'b0);
    chk("lit_to_done", done,     1'b1);
    chk("lit_to_idok", id_ok,    1'b0);
    at_k(7);

    // Stuck waitrequest on the timestamp read.
    s_wid = 0; s_wts = 1000;
    start_run();
    at_k(done_k() + 2);

    // Mismatch, then corrected slave with ignored start pulses mid-check.
    s_id = 32'd12; s_wts = 0;
    start_run();
    at_k(done_k() + 1);
    s_id = EXP_ID; s_wid = 2; s_wts = 2;
    start_run();
    at_k(0);
    chk("lit_rerun_clear", id_ok,    1'b0);
    chk("lit_rerun_keep",  id_value, 32'd12);
    pulse_at(1);
    pulse_at(TS_EN ? 4 : 2);
    at_k(done_k());
    chk("lit_rerun_done",  done,  1'b1);
    chk("lit_rerun_id_ok", id_ok, 1'b1);
    at_k(done_k() + 2);

    // Reset while the second read is stalled.
    s_wid = 0; s_wts = 1000;
    start_run();
    at_k(1);
    @(posedge clock); #2;
    reset = 1'b1; in_reset = 1'b1; p_id = '0; p_ts = '0;
    #1;
    chk("lit_rst_read", avm_read, 1'b0);
    chk("lit_rst_busy", busy,     1'b0);
    chk("lit_rst_idv",  id_value, 32'd0);
    repeat (2) @(posedge clock);
    s_wts = 0;
    release_reset();
    at_k(0);
    chk("lit_restart_read", avm_read,    1'b1);
    chk("lit_restart_addr", avm_address, 1'b0);
    at_k(ZW_DONE);
    chk("lit_restart_done", done, 1'b1);
    at_k(ZW_DONE + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
